mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the number of REQ cycles without mem_ack before a bus error is declared (range 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request from the pipeline to begin an access.
REQ-005 SHALL have port memop  input  3  access type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-006 SHALL have port addr  input  32  byte address, taken from ALU output.
REQ-007 SHALL have port wdata  input  32  store data, taken from busb.
REQ-008 SHALL have port busy  output  1  high while an access is in flight.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port dout  output  32  aligned and extended load result, feeding the writeback select "dout" input.
REQ-011 SHALL have port bus_err  output  1  high with done when the access timed out.
REQ-012 SHALL have ports adel and ades  output  1 each  load and store address-error flags, valid with done.
REQ-013 SHALL have ports mem_req (output 1), mem_we (output 1), mem_addr (output 32, word-aligned), mem_be (output 4), mem_wdata (output 32), mem_ack (input 1) and mem_rdata (input 32).

Function
REQ-014 SHALL implement FSM states IDLE, REQ and DONE; IDLE→REQ on start; REQ→DONE on mem_ack or timeout; DONE→IDLE unconditionally.
REQ-015 SHALL latch memop, addr and wdata on the start cycle; start while busy=1 SHALL be ignored.
REQ-016 SHALL assert mem_req in the cycle after start and hold mem_req, mem_we, mem_addr, mem_be and mem_wdata stable until the mem_ack cycle.
REQ-017 SHALL assert done exactly one cycle after the mem_ack cycle, so latency is start→done = ack wait + 2 cycles, or 2 cycles with zero-wait ack.
REQ-018 SHALL use little-endian byte lanes: mem_be is 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half and 1111 for word; mem_addr = {addr[31:2],2'b00}.
REQ-019 SHALL replicate store data across lanes (SB: byte ×4; SH: half ×2; SW: as-is), with mem_we=1 for SB/SH/SW only.
REQ-020 SHALL register dout from mem_rdata on mem_ack: extract the lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; stores give dout=0.
REQ-021 SHALL count REQ cycles; when count reaches TIMEOUT_CYC without ack, it SHALL drop mem_req, go to DONE, and pulse done with bus_err=1 and dout=0.
REQ-022 SHALL give mem_ack priority when mem_ack arrives in the timeout cycle (no bus_err).
REQ-023 SHALL ignore mem_ack outside REQ.
REQ-024 SHALL hold dout, bus_err, adel and ades from done until the next start.

Reset
REQ-025 SHALL on rst_n=0 immediately force state IDLE and set mem_req, mem_we, busy, done, bus_err, adel and ades to 0, mem_be=0, and dout, mem_addr, mem_wdata and the counter to 0, including when reset arrives mid-access.

Configuration
REQ-026 SHALL behave as follows with MEM_ALIGN_CHECK_EN defined:
- a misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠00) issues no mem_req;
- done pulses 2 cycles after start;
- adel=1 for loads or ades=1 for stores, with dout=0.
REQ-027 SHALL behave as follows without MEM_ALIGN_CHECK_EN: adel and ades are tied 0, and misaligned halfword/word accesses use addr with the offending low bits treated as 0.

Structure
REQ-028 SHALL place the memop encodings and the FSM state typedef in the shared package mips_pkg.
REQ-029 SHALL use a combinational sub-module mem_ld_ext for load lane extraction and extension.

Verification
REQ-030 SHALL cover: LW addr=0x100, mem_ack same cycle as first mem_req, mem_rdata=0xDEADBEEF -> mem_be=1111, done 2 cycles after start, dout=0xDEADBEEF.
REQ-031 SHALL cover: LB addr=0x103, rdata=0x80FFFFFF, ack after 3 wait cycles -> mem_be=1000, dout=0xFFFFFF80, done 5 cycles after start; LBU with the same stimulus -> dout=0x00000080.
REQ-032 SHALL cover: SH addr=0x202, wdata=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200.
REQ-033 SHALL cover: TIMEOUT_CYC=4, LW with mem_ack never asserted -> mem_req high 4 cycles then low, done with bus_err=1 and dout=0.
REQ-034 SHALL cover: SW addr=0x301 with MEM_ALIGN_CHECK_EN -> no mem_req, done at start+2 with ades=1; without the macro -> mem_addr=0x300 and mem_be=1111.
REQ-035 SHALL cover: rst_n asserted low during REQ -> mem_req low in the same cycle; after release, start asserted again -> a normal access completes.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared memory-stage types: memop encodings, access FSM states, lane helpers.
package mips_pkg;

    typedef enum logic [2:0] {
        MOP_LB  = 3'b000,
        MOP_LH  = 3'b001,
        MOP_LW  = 3'b010,
        MOP_LBU = 3'b011,
        MOP_LHU = 3'b100,
        MOP_SB  = 3'b101,
        MOP_SH  = 3'b110,
        MOP_SW  = 3'b111
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic is_store(memop_e op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
    endfunction

    function automatic logic [1:0] acc_size(memop_e op);
        logic [1:0] sz;
        case (op)
            MOP_LB, MOP_LBU, MOP_SB: sz = SZ_BYTE;
            MOP_LH, MOP_LHU, MOP_SH: sz = SZ_HALF;
            default:                 sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(memop_e op, logic [1:0] off);
        logic [1:0] sz;
        sz = acc_size(op);
        return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

    // Offending low address bits are dropped so a misaligned access lands on its container.
    function automatic logic [1:0] eff_off(memop_e op, logic [1:0] off);
        logic [1:0] r;
        case (acc_size(op))
            SZ_BYTE: r = off;
            SZ_HALF: r = {off[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_mask(memop_e op, logic [1:0] off);
        logic [3:0] m;
        case (acc_size(op))
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_wdata(memop_e op, logic [31:0] wd);
        logic [31:0] r;
        case (acc_size(op))
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ld_ext.sv
// Load lane extraction: picks the addressed byte/half from the bus word and extends it.
module mem_ld_ext
    import mips_pkg::*;
(
    input  memop_e      op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [15:0] lane;

    always_comb begin
        lane = 16'(rdata >> {off, 3'b000});
        case (op)
            MOP_LB:  data = {{24{lane[7]}}, lane[7:0]};
            MOP_LH:  data = {{16{lane[15]}}, lane};
            MOP_LW:  data = rdata;
            MOP_LBU: data = {24'd0, lane[7:0]};
            MOP_LHU: data = {16'd0, lane};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage access sequencer: one bus transaction per start, with timeout.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses skip the bus and raise adel/ades.
module mem_access
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  memop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] dout,
    output logic        bus_err,
    output logic        adel,
    output logic        ades,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    mem_state_e  state_q, state_d;
    memop_e      op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        misal_q, misal_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] dout_q, dout_d;
    logic        bus_err_q, bus_err_d;
    logic        adel_q, adel_d;
    logic        ades_q, ades_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    memop_e      op_in;
    logic [1:0]  off_in;
    logic        mis_in;
    logic [31:0] ld_data;

    mem_ld_ext u_ld_ext (
        .op    (op_q),
        .off   (off_q),
        .rdata (mem_rdata),
        .data  (ld_data)
    );

    always_comb begin
        op_in  = memop_e'(memop);
        off_in = eff_off(op_in, addr[1:0]);
`ifdef MEM_ALIGN_CHECK_EN
        mis_in = is_misaligned(op_in, addr[1:0]);
`else
        mis_in = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        misal_d     = misal_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dout_d      = dout_q;
        bus_err_d   = bus_err_q;
        adel_d      = adel_q;
        ades_d      = ades_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_REQ;
                    op_d        = op_in;
                    off_d       = off_in;
                    cnt_d       = 8'd0;
                    misal_d     = mis_in;
                    busy_d      = 1'b1;
                    dout_d      = 32'd0;
                    bus_err_d   = 1'b0;
                    adel_d      = 1'b0;
                    ades_d      = 1'b0;
                    mem_req_d   = !mis_in;
                    mem_we_d    = !mis_in && is_store(op_in);
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = lane_mask(op_in, off_in);
                    mem_wdata_d = lane_wdata(op_in, wdata);
                end
            end
            ST_REQ: begin
                if (misal_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    adel_d  = !is_store(op_q);
                    ades_d  = is_store(op_q);
                end else if (mem_ack) begin
                    // Ack wins even in the cycle the counter expires.
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    dout_d    = is_store(op_q) ? 32'd0 : ld_data;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= MOP_LB;
            off_q       <= 2'b00;
            cnt_q       <= 8'd0;
            misal_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dout_q      <= 32'd0;
            bus_err_q   <= 1'b0;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            misal_q     <= misal_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dout_q      <= dout_d;
            bus_err_q   <= bus_err_d;
            adel_q      <= adel_d;
            ades_q      <= ades_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dout      = dout_q;
    assign bus_err   = bus_err_q;
    assign adel      = adel_q;
    assign ades      = ades_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus random accesses against a lane-level model.
module tb_mem_access;

    localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  memop = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, bus_err, adel, ades;
    logic [31:0] dout;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int vec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .memop(memop), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .dout(dout), .bus_err(bus_err),
        .adel(adel), .ades(ades), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: access width in bytes, lanes covered, store replication, load extension.
    function automatic int nbytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    task automatic do_access(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int w);
        int          sz, off, k;
        bit          st, mis, acked, timed;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld, mask, held;
        sz  = nbytes(op);
        st  = (op >= 3'd5);
        mis = (a % sz) != 0;
        off = (a % 4) - ((a % 4) % sz);
        ebe = 4'd0;
        for (int i = 0; i < sz; i++) ebe[off + i] = 1'b1;
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
        eld  = (rd >> (8*off)) & mask;
        if ((op == 3'd0 || op == 3'd1) && eld[8*sz-1]) eld = eld | ~mask;
        if (st) eld = 32'd0;

        @(posedge clk); #1;
        start = 1'b1; memop = op; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0; memop = 3'($urandom); addr = $urandom; wdata = $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (ALIGN_CHK && mis) begin
            chk("misal_no_req", {31'd0, mem_req}, 32'd0);
            @(posedge clk); #1;
            chk("misal_done", {31'd0, done}, 32'd1);
            chk("adel", {31'd0, adel}, {31'd0, !st});
            chk("ades", {31'd0, ades}, {31'd0, st});
            chk("misal_dout", dout, 32'd0);
            chk("misal_bus_err", {31'd0, bus_err}, 32'd0);
        end else begin
            k = 0; acked = 0; timed = 0;
            while (!acked && !timed) begin
                chk("mem_req", {31'd0, mem_req}, 32'd1);
                chk("mem_we", {31'd0, mem_we}, {31'd0, st});
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_be", {28'd0, mem_be}, {28'd0, ebe});
                if (st) chk("mem_wdata", mem_wdata, ewd);
                chk("done_early", {31'd0, done}, 32'd0);
                // A second start while busy must be ignored.
                if (k == 0) begin start = 1'b1; memop = 3'($urandom); end
                if (k == w) begin mem_ack = 1'b1; mem_rdata = rd; end
                else mem_rdata = $urandom;
                @(posedge clk); #1;
                mem_ack = 1'b0; start = 1'b0;
                if (k == w) acked = 1;
                else if (k == TO - 1) timed = 1;
                k++;
            end
            chk("done", {31'd0, done}, 32'd1);
            chk("req_dropped", {31'd0, mem_req}, 32'd0);
            chk("bus_err", {31'd0, bus_err}, {31'd0, timed});
            chk("dout", dout, timed ? 32'd0 : eld);
            chk("adel_ades", {30'd0, adel, ades}, 32'd0);
        end
        held = dout;
        mem_ack = 1'b1; mem_rdata = ~rd;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("done_pulse_end", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("dout_held", dout, held);
    endtask

    initial begin
        logic [31:0] ra, rw, rr;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        do_access(3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);     // LW zero-wait
        do_access(3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 3);     // LB, ack in the timeout cycle
        do_access(3'd3, 32'h103, 32'h0, 32'h80FFFFFF, 3);     // LBU
        do_access(3'd6, 32'h202, 32'h1234ABCD, 32'h0, 1);     // SH
        do_access(3'd2, 32'h400, 32'h0, 32'h11111111, 99);    // LW timeout
        do_access(3'd7, 32'h301, 32'hCAFEF00D, 32'h0, 0);     // SW misaligned
        do_access(3'd1, 32'h501, 32'h0, 32'h8001_7F02, 2);    // LH misaligned
        do_access(3'd4, 32'h502, 32'h0, 32'h8001_7F02, 0);    // LHU upper half
        do_access(3'd5, 32'h603, 32'hA5A5_A55A, 32'h0, 2);    // SB

        // Reset in the middle of REQ.
        @(posedge clk); #1;
        start = 1'b1; memop = 3'd2; addr = 32'h700;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        chk("midrst_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_addr", mem_addr, 32'd0);
        chk("midrst_be", {28'd0, mem_be}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        do_access(3'd2, 32'h704, 32'h0, 32'h0BAD_F00D, 1);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom; rw = $urandom; rr = $urandom;
            do_access(3'($urandom_range(0, 7)), ra, rw, rr, $urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, nerr);
        $finish;
    end

endmodule
